trng_vn_byte_assembler: RTL

//   Downstream consumer of the SR-latch entropy network's raw output bit. Applies
//   von Neumann debiasing and a repetition-count health test, then packs the debiased

---
 rtl/trng_vn_byte_assembler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/trng_vn_byte_assembler.sv
// -----------------------------------------------------------------------------
// trng_vn_byte_assembler
//
// Takes the raw bit from the SR-latch entropy network, removes bias with a
// von Neumann pair extractor, watches the raw stream with a repetition-count
// health test, and packs debiased bits MSB-first into WIDTH-bit words. Words
// sit in a small FIFO and are handed out over a valid/ready interface.
//
// State table (pair extractor):
//   state      | meaning
//   IDLE       | waiting for the first bit of a raw pair
//   HAVE_FIRST | first bit of the pair held in first_q
//
// Ports:
//   clk          in   1      single clock, all state on posedge
//   rst_n        in   1      asynchronous, active-low reset
//   enabled      in   1      raw_bit is a valid sample at this edge
//   raw_bit      in   1      raw entropy bit
//   out_data     out  WIDTH  FIFO head word, 0 when nothing is offered
//   out_valid    out  1      FIFO non-empty and health test passing
//   out_ready    in   1      consumer takes out_data at this edge when valid
//   health_fail  out  1      sticky repetition-test failure
//   drop_cnt     out  8      words lost to a full FIFO, saturating at 255
// -----------------------------------------------------------------------------
module trng_vn_byte_assembler #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enabled,
  input  logic             raw_bit,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             health_fail,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE       = 1'b0,
    HAVE_FIRST = 1'b1
  } pair_state_t;

  // ---------------------------------------------------------------------------
  // Pair extractor
  // ---------------------------------------------------------------------------
  pair_state_t state_q, state_d;
  logic        first_q, first_d;
  logic        emit;
  logic        emit_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    first_d  = first_q;
    emit     = 1'b0;
    emit_bit = first_q;
    if (!enabled) begin
      // a gap in sampling breaks the pair; the held first bit is abandoned
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = HAVE_FIRST;
          first_d = raw_bit;
        end
        HAVE_FIRST: begin
          state_d = IDLE;
          emit    = (raw_bit != first_q);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Word assembler
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_q;
  logic [CW-1:0]    bit_cnt_q;
  logic [WIDTH-1:0] shifted;
  logic             word_done;

  assign shifted   = {shift_q[WIDTH-2:0], emit_bit};
  assign word_done = emit && (bit_cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (emit) begin
      if (word_done) begin
        shift_q   <= '0;
        bit_cnt_q <= '0;
      end else begin
        shift_q   <= shifted;
        bit_cnt_q <= bit_cnt_q + CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Repetition-count health test on raw samples
  // ---------------------------------------------------------------------------
  logic [RW-1:0] rep_q, rep_d;
  logic          last_q;

  always_comb begin
    rep_d = rep_q;
    if (enabled) begin
      // rep_q == 0 only before the first sample after reset
      if ((rep_q == '0) || (raw_bit != last_q))
        rep_d = RW'(1);
      else if (rep_q != RW'(REP_LIMIT))
        rep_d = rep_q + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q       <= '0;
      last_q      <= 1'b0;
      health_fail <= 1'b0;
    end else begin
      rep_q <= rep_d;
      if (enabled)
        last_q <= raw_bit;
      if (enabled && (rep_d == RW'(REP_LIMIT)))
        health_fail <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q, rd_q;
  logic [PW-1:0]    fill;
  logic             empty, full;
  logic             pop, push_req, push, drop;

  assign fill     = wr_q - rd_q;
  assign empty    = (wr_q == rd_q);
  assign full     = (fill == PW'(DEPTH));
  assign out_valid = !empty && !health_fail;
  assign out_data  = out_valid ? mem[rd_q[AW-1:0]] : '0;
  assign pop      = out_valid && out_ready;
  assign push_req = word_done && !health_fail;
  // a full FIFO still takes the word when the head leaves at the same edge
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && !push;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_q[AW-1:0]] <= shifted;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (health_fail) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push)
        wr_q <= wr_q + PW'(1);
      if (pop)
        rd_q <= rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= 8'd0;
    else if (drop && (drop_cnt != 8'hFF))
      drop_cnt <= drop_cnt + 8'd1;
  end

endmodule
